cond_exec_stage: RTL and testbench

COND_EXEC_STAGE -- requirements
Module: cond_exec_stage

---
 rtl/cond_exec_stage.sv | 164 ++++++++++++++++
 tb/tb_cond_exec_stage.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_stage.sv
// cond_exec_stage
//
// Execute-stage pipeline register plus conditional-execution logic for an
// ARM-style pipeline. It registers the decode-stage controls into the E
// stage, evaluates the instruction condition against the architectural NZCV
// flags, gates the side-effecting controls with the pass result, and updates
// the flags from the ALU.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stallE, flushE      hold / bubble the E-stage register (flush wins)
//   *D inputs           decode-stage controls and condition field
//   ALUFlags            {N,Z,C,V} from the ALU for the instruction now in E
//   resultSrcE, ALUControlE, ALUSrcE, movImmE
//                       registered E-stage copies (not condition gated)
//   regWriteCE, memWriteCE, PCSrcCE
//                       registered controls gated by condExE
//   branchTakenE        taken branch or BX (write to PC) in E
//   condExE             condition-pass for the instruction in E
//   flags               architectural NZCV register
module cond_exec_stage #(
    parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stallE,
    input  logic       flushE,
    input  logic       regWriteD,
    input  logic       memWriteD,
    input  logic       branchD,
    input  logic       PCSrcD,
    input  logic       ALUSrcD,
    input  logic       movImmD,
    input  logic [1:0] resultSrcD,
    input  logic [3:0] ALUControlD,
    input  logic [1:0] flagWriteD,
    input  logic [3:0] condD,
    input  logic [3:0] ALUFlags,
    output logic [1:0] resultSrcE,
    output logic [3:0] ALUControlE,
    output logic       ALUSrcE,
    output logic       movImmE,
    output logic       regWriteCE,
    output logic       memWriteCE,
    output logic       PCSrcCE,
    output logic       branchTakenE,
    output logic       condExE,
    output logic [3:0] flags
);

    localparam logic [3:0] COND_AL = 4'b1110;

    // E-stage register
    logic       r_regWriteE;
    logic       r_memWriteE;
    logic       r_branchE;
    logic       r_PCSrcE;
    logic       r_ALUSrcE;
    logic       r_movImmE;
    logic [1:0] r_resultSrcE;
    logic [3:0] r_ALUControlE;
    logic [1:0] r_flagWriteE;
    logic [3:0] r_condE;

    // Architectural flags {N,Z,C,V}
    logic [3:0] r_flags;

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_condExE;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Condition check always uses the flags as they stand before this
    // instruction's own flag update lands at the next edge.
    always_comb begin
        w_condExE = 1'b0;
        case (r_condE)
            4'd0:    w_condExE = w_z;
            4'd1:    w_condExE = ~w_z;
            4'd2:    w_condExE = w_c;
            4'd3:    w_condExE = ~w_c;
            4'd4:    w_condExE = w_n;
            4'd5:    w_condExE = ~w_n;
            4'd6:    w_condExE = w_v;
            4'd7:    w_condExE = ~w_v;
            4'd8:    w_condExE = w_c & ~w_z;
            4'd9:    w_condExE = ~w_c | w_z;
            4'd10:   w_condExE = (w_n == w_v);
            4'd11:   w_condExE = (w_n != w_v);
            4'd12:   w_condExE = ~w_z & (w_n == w_v);
            4'd13:   w_condExE = w_z | (w_n != w_v);
            4'd14:   w_condExE = 1'b1;
            default: w_condExE = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regWriteE   <= 1'b0;
            r_memWriteE   <= 1'b0;
            r_branchE     <= 1'b0;
            r_PCSrcE      <= 1'b0;
            r_ALUSrcE     <= 1'b0;
            r_movImmE     <= 1'b0;
            r_resultSrcE  <= 2'b00;
            r_ALUControlE <= 4'b0000;
            r_flagWriteE  <= 2'b00;
            r_condE       <= COND_AL;
            r_flags       <= FLAGS_INIT;
        end else begin
            // A bubble is an always-executing no-op so condExE stays 1.
            if (flushE) begin
                r_regWriteE   <= 1'b0;
                r_memWriteE   <= 1'b0;
                r_branchE     <= 1'b0;
                r_PCSrcE      <= 1'b0;
                r_ALUSrcE     <= 1'b0;
                r_movImmE     <= 1'b0;
                r_resultSrcE  <= 2'b00;
                r_ALUControlE <= 4'b0000;
                r_flagWriteE  <= 2'b00;
                r_condE       <= COND_AL;
            end else if (!stallE) begin
                r_regWriteE   <= regWriteD;
                r_memWriteE   <= memWriteD;
                r_branchE     <= branchD;
                r_PCSrcE      <= PCSrcD;
                r_ALUSrcE     <= ALUSrcD;
                r_movImmE     <= movImmD;
                r_resultSrcE  <= resultSrcD;
                r_ALUControlE <= ALUControlD;
                r_flagWriteE  <= flagWriteD;
                r_condE       <= condD;
            end

            // Flags are written by the instruction occupying E regardless
            // of stall; a failed condition suppresses the write.
            if (r_flagWriteE[1] && w_condExE) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (r_flagWriteE[0] && w_condExE) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign resultSrcE   = r_resultSrcE;
    assign ALUControlE  = r_ALUControlE;
    assign ALUSrcE      = r_ALUSrcE;
    assign movImmE      = r_movImmE;
    assign regWriteCE   = r_regWriteE & w_condExE;
    assign memWriteCE   = r_memWriteE & w_condExE;
    assign PCSrcCE      = r_PCSrcE & w_condExE;
    assign branchTakenE = (r_branchE | r_PCSrcE) & w_condExE;
    assign condExE      = w_condExE;
    assign flags        = r_flags;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Testbench for cond_exec_stage. Observed outputs are packed as
// {regWriteCE, memWriteCE, PCSrcCE, branchTakenE, condExE, ALUSrcE, movImmE,
//  resultSrcE, ALUControlE, flags}. Inputs change on the falling edge and
// outputs are sampled on the next falling edge, after the rising edge between.
module tb_cond_exec_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       stallE = 1'b0;
  logic       flushE = 1'b0;
  logic       regWriteD = 1'b0;
  logic       memWriteD = 1'b0;
  logic       branchD = 1'b0;
  logic       PCSrcD = 1'b0;
  logic       ALUSrcD = 1'b0;
  logic       movImmD = 1'b0;
  logic [1:0] resultSrcD = 2'b00;
  logic [3:0] ALUControlD = 4'b0000;
  logic [1:0] flagWriteD = 2'b00;
  logic [3:0] condD = 4'b1110;
  logic [3:0] ALUFlags = 4'b0000;

  logic [1:0] resultSrcE;
  logic [3:0] ALUControlE;
  logic       ALUSrcE;
  logic       movImmE;
  logic       regWriteCE;
  logic       memWriteCE;
  logic       PCSrcCE;
  logic       branchTakenE;
  logic       condExE;
  logic [3:0] flags;

  cond_exec_stage dut (
    .clk(clk),
    .reset(reset),
    .stallE(stallE),
    .flushE(flushE),
    .regWriteD(regWriteD),
    .memWriteD(memWriteD),
    .branchD(branchD),
    .PCSrcD(PCSrcD),
    .ALUSrcD(ALUSrcD),
    .movImmD(movImmD),
    .resultSrcD(resultSrcD),
    .ALUControlD(ALUControlD),
    .flagWriteD(flagWriteD),
    .condD(condD),
    .ALUFlags(ALUFlags),
    .resultSrcE(resultSrcE),
    .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE),
    .movImmE(movImmE),
    .regWriteCE(regWriteCE),
    .memWriteCE(memWriteCE),
    .PCSrcCE(PCSrcCE),
    .branchTakenE(branchTakenE),
    .condExE(condExE),
    .flags(flags)
  );

  logic [16:0] obs;
  assign obs = {regWriteCE, memWriteCE, PCSrcCE, branchTakenE, condExE,
                ALUSrcE, movImmE, resultSrcE, ALUControlE, flags};

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  logic [16:0] exp_v;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [16:0] mk(input bit rw, input bit mw, input bit pc,
                                     input bit bt, input bit ce, input bit as,
                                     input bit mi, input logic [1:0] rs,
                                     input logic [3:0] ac, input logic [3:0] fl);
    return {rw, mw, pc, bt, ce, as, mi, rs, ac, fl};
  endfunction

  // Reference condition table, written from the ARM condition definitions.
  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_d(input bit rw, input bit mw, input bit br, input bit pcs,
                       input bit as, input bit mi, input logic [1:0] rs,
                       input logic [3:0] ac, input logic [1:0] fw,
                       input logic [3:0] cond);
    regWriteD = rw; memWriteD = mw; branchD = br; PCSrcD = pcs;
    ALUSrcD = as; movImmD = mi; resultSrcD = rs; ALUControlD = ac;
    flagWriteD = fw; condD = cond;
  endtask

  task automatic set_nop();
    set_d(0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 4'd14);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; stallE = 1'b0; flushE = 1'b0; ALUFlags = 4'b0000;
    set_nop();
    tick();
    reset = 1'b0;
  endtask

  // Loads flags through an always-executing flag-setting instruction.
  task automatic load_flags(input logic [3:0] f);
    set_d(0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b11, 4'd14);
    tick();
    ALUFlags = f;
    set_nop();
    tick();
    ALUFlags = 4'b0000;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    set_d(1, 1, 1, 1, 1, 1, 2'b11, 4'b1111, 2'b11, 4'd0);
    ALUFlags = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 4'b0000));
      tick();
      exp_v = exp_q.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL reset[%0d]: got %b expected %b", i, obs, exp_v);
      end
    end
    reset = 1'b0; ALUFlags = 4'b0000;
    set_nop();
  endtask

  task automatic test_basic();
    set_d(1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 4'd14);
    exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 4'b0000));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL basic_al: got %b expected %b", obs, exp_v);
    end
  endtask

  task automatic test_cmp_dependency();
    do_reset();
    set_d(0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b11, 4'd14);
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 4'b0000));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL cmp_in_e: got %b expected %b", obs, exp_v);
    end
    ALUFlags = 4'b0100;
    set_d(1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 4'd0);
    exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 4'b0100));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL cmp_then_eq: got %b expected %b", obs, exp_v);
    end
    ALUFlags = 4'b1011;
    set_d(1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 4'd1);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 4'b0100));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL cmp_then_ne: got %b expected %b", obs, exp_v);
    end
    ALUFlags = 4'b0000;
  endtask

  task automatic test_partial_flags();
    do_reset();
    set_d(0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b10, 4'd14);
    tick();
    ALUFlags = 4'b1011;
    set_d(0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b01, 4'd14);
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 4'b1000));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL flags_nz_only: got %b expected %b", obs, exp_v);
    end
    ALUFlags = 4'b0111;
    set_nop();
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 4'b1011));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL flags_cv_only: got %b expected %b", obs, exp_v);
    end
    ALUFlags = 4'b0000;
  endtask

  task automatic test_stall_flush();
    do_reset();
    set_d(1, 1, 0, 0, 1, 0, 2'b10, 4'b0011, 2'b00, 4'd14);
    tick();
    stallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_d(0, 0, 1, 1, 0, 1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            2'b00, 4'd15);
      exp_q.push_back(mk(1, 1, 0, 0, 1, 1, 0, 2'b10, 4'b0011, 4'b0000));
      tick();
      exp_v = exp_q.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL stall_hold[%0d]: got %b expected %b", i, obs, exp_v);
      end
    end
    flushE = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 4'b0000));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL flush_over_stall: got %b expected %b", obs, exp_v);
    end
    stallE = 1'b0; flushE = 1'b0;
    set_nop();
  endtask

  task automatic test_stall_flag_write();
    do_reset();
    set_d(0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b11, 4'd14);
    tick();
    stallE = 1'b1; ALUFlags = 4'b0110;
    set_d(1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 4'd14);
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 4'b0110));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL flags_during_stall: got %b expected %b", obs, exp_v);
    end
    // Held instruction still in E writes again while the flush lands.
    stallE = 1'b0; flushE = 1'b1; ALUFlags = 4'b1001;
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 4'b1001));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL flags_at_flush: got %b expected %b", obs, exp_v);
    end
    flushE = 1'b0; ALUFlags = 4'b0000;
    set_nop();
  endtask

  task automatic test_branch();
    do_reset();
    load_flags(4'b1000);
    set_d(0, 0, 1, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 4'd10);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 4'b1000));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL branch_ge_fail: got %b expected %b", obs, exp_v);
    end
    load_flags(4'b1001);
    set_d(0, 0, 1, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 4'd10);
    exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2'b00, 4'b0000, 4'b1001));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL branch_ge_pass: got %b expected %b", obs, exp_v);
    end
    set_d(0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 2'b00, 4'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 4'b1001));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL pcsrc_eq_fail: got %b expected %b", obs, exp_v);
    end
    set_d(0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 2'b00, 4'd14);
    exp_q.push_back(mk(0, 0, 1, 1, 1, 0, 0, 2'b00, 4'b0000, 4'b1001));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL pcsrc_al: got %b expected %b", obs, exp_v);
    end
    set_nop();
  endtask

  task automatic test_never();
    do_reset();
    load_flags(4'b0101);
    set_d(0, 1, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b11, 4'd15);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 4'b0101));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL never_in_e: got %b expected %b", obs, exp_v);
    end
    ALUFlags = 4'b1010;
    set_nop();
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 4'b0101));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL never_no_flags: got %b expected %b", obs, exp_v);
    end
    ALUFlags = 4'b0000;
  endtask

  task automatic test_reset_override();
    do_reset();
    load_flags(4'b0110);
    set_d(1, 1, 1, 1, 1, 1, 2'b11, 4'b1010, 2'b11, 4'd14);
    tick();
    reset = 1'b1; stallE = 1'b1; flushE = 1'b1; ALUFlags = 4'b1111;
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 4'b0000));
    tick();
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL reset_override: got %b expected %b", obs, exp_v);
    end
    reset = 1'b0; stallE = 1'b0; flushE = 1'b0; ALUFlags = 4'b0000;
    set_nop();
  endtask

  task automatic test_cond_table();
    logic [3:0] f;
    logic [1:0] rs;
    logic [3:0] ac;
    bit         mi;
    bit         p;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      f  = 4'($urandom_range(0, 15));
      rs = 2'($urandom_range(0, 3));
      ac = 4'($urandom_range(0, 15));
      mi = 1'($urandom_range(0, 1));
      set_d(0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b11, 4'd14);
      tick();
      ALUFlags = f;
      set_d(1, 0, 0, 0, 0, mi, rs, ac, 2'b00, 4'(k % 16));
      p = cond_pass(4'(k % 16), f);
      exp_q.push_back(mk(p, 0, 0, 0, p, 0, mi, rs, ac, f));
      tick();
      ALUFlags = 4'($urandom_range(0, 15));
      exp_v = exp_q.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL cond_%0d flags=%b: got %b expected %b", k % 16, f, obs, exp_v);
      end
    end
    ALUFlags = 4'b0000;
    set_nop();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_cmp_dependency();
    test_partial_flags();
    test_stall_flush();
    test_stall_flag_write();
    test_branch();
    test_never();
    test_reset_override();
    test_cond_table();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
